// File: rtl/layer_stream_serializer.sv
// layer_stream_serializer
//   Captures one full layer output vector (NUM_CH values) into a two-entry ping-pong buffer
//   and streams it downstream one value per beat with valid/ready handshaking. The next
//   vector can be captured while the current one drains. Vectors that arrive with no free
//   buffer are dropped and accounted for in a sticky flag plus a saturating counter.
//
// Ports
//   clk            clock, all flops on posedge
//   rst            asynchronous active-high reset
//   i_valid        single-cycle pulse: i_data holds a full vector
//   i_data         vector, channel c = i_data[c*DATA_WIDTH +: DATA_WIDTH]
//   o_data         current beat value
//   o_valid        beat valid
//   o_last         final beat of a vector
//   i_ready        downstream accepts the beat
//   o_busy         at least one buffer occupied
//   o_overflow     sticky: a vector was dropped
//   o_drop_cnt     saturating count of dropped vectors
//   i_clr_overflow clears o_overflow and o_drop_cnt (a same-cycle drop takes priority)
module layer_stream_serializer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CH     = 10,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_valid,
    output logic                         o_last,
    input  logic                         i_ready,
    output logic                         o_busy,
    output logic                         o_overflow,
    output logic [7:0]                   o_drop_cnt,
    input  logic                         i_clr_overflow
);

    localparam int unsigned   BeatW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(NUM_CH - 1);

    logic [NUM_CH*DATA_WIDTH-1:0] vec_q [2];
    logic                         wr_ptr_q, wr_ptr_d;
    logic                         rd_ptr_q, rd_ptr_d;
    logic [1:0]                   occ_q, occ_d;
    logic [BeatW-1:0]             beat_q, beat_d;
    logic                         ovf_q, ovf_d;
    logic [7:0]                   cnt_q, cnt_d;

    logic                         xfer;
    logic                         last_xfer;
    logic                         accept;
    logic                         drop;
    logic [BeatW-1:0]             ch;
    logic [NUM_CH*DATA_WIDTH-1:0] cur_vec;

    assign xfer      = o_valid && i_ready;
    assign last_xfer = xfer && (beat_q == LastBeat);
    // A full buffer pair can still take a vector when the oldest one frees up this cycle.
    assign accept    = i_valid && ((occ_q != 2'd2) || last_xfer);
    assign drop      = i_valid && !accept;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        beat_d   = beat_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;

        if (accept) begin
            wr_ptr_d = ~wr_ptr_q;
        end

        if (xfer) begin
            if (beat_q == LastBeat) begin
                beat_d   = '0;
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                beat_d = beat_q + BeatW'(1);
            end
        end

        if (accept && !last_xfer) begin
            occ_d = occ_q + 2'd1;
        end else if (!accept && last_xfer) begin
            occ_d = occ_q - 2'd1;
        end

        if (drop) begin
            ovf_d = 1'b1;
            if (i_clr_overflow) begin
                cnt_d = 8'd1;
            end else if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (i_clr_overflow) begin
            ovf_d = 1'b0;
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q[0] <= '0;
            vec_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            beat_q   <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            if (accept) begin
                vec_q[wr_ptr_q] <= i_data;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            beat_q   <= beat_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decode registers only; buffers clear on reset so o_data reads 0 then.
    always_comb begin
        ch      = LSB_FIRST ? beat_q : (LastBeat - beat_q);
        cur_vec = vec_q[rd_ptr_q];
        o_data  = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch == BeatW'(c)) begin
                o_data = cur_vec[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_valid    = (occ_q != 2'd0);
    assign o_busy     = (occ_q != 2'd0);
    assign o_last     = o_valid && (beat_q == LastBeat);
    assign o_overflow = ovf_q;
    assign o_drop_cnt = cnt_q;

endmodule

// File: tb/tb_layer_stream_serializer.sv
module tb_layer_stream_serializer;

    localparam logic [63:0] V1 = {16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [63:0] V2 = {16'd8, 16'd7, 16'd6, 16'd5};
    localparam logic [63:0] V3 = {16'd12, 16'd11, 16'd10, 16'd9};
    localparam logic [63:0] V4 = {16'd16, 16'd15, 16'd14, 16'd13};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: 16-bit, 4 channels, LSB first
    logic        a_valid = 1'b0, a_ready = 1'b1, a_clr = 1'b0;
    logic [63:0] a_data = '0;
    logic [15:0] a_odata;
    logic        a_ovalid, a_olast, a_busy, a_ovf;
    logic [7:0]  a_cnt;

    // DUT B: 16-bit, 4 channels, MSB first
    logic        b_valid = 1'b0, b_ready = 1'b1, b_clr = 1'b0;
    logic [63:0] b_data = '0;
    logic [15:0] b_odata;
    logic        b_ovalid, b_olast, b_busy, b_ovf;
    logic [7:0]  b_cnt;

    // DUT C: 8-bit, 30 channels, LSB first
    logic         c_valid = 1'b0, c_ready = 1'b1, c_clr = 1'b0;
    logic [239:0] c_data = '0;
    logic [7:0]   c_odata;
    logic         c_ovalid, c_olast, c_busy, c_ovf;
    logic [7:0]   c_cnt;

    layer_stream_serializer #(.DATA_WIDTH(16), .NUM_CH(4), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .i_valid(a_valid), .i_data(a_data), .o_data(a_odata),
        .o_valid(a_ovalid), .o_last(a_olast), .i_ready(a_ready), .o_busy(a_busy),
        .o_overflow(a_ovf), .o_drop_cnt(a_cnt), .i_clr_overflow(a_clr)
    );

    layer_stream_serializer #(.DATA_WIDTH(16), .NUM_CH(4), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .i_valid(b_valid), .i_data(b_data), .o_data(b_odata),
        .o_valid(b_ovalid), .o_last(b_olast), .i_ready(b_ready), .o_busy(b_busy),
        .o_overflow(b_ovf), .o_drop_cnt(b_cnt), .i_clr_overflow(b_clr)
    );

    layer_stream_serializer #(.DATA_WIDTH(8), .NUM_CH(30), .LSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst(rst), .i_valid(c_valid), .i_data(c_data), .o_data(c_odata),
        .o_valid(c_ovalid), .o_last(c_olast), .i_ready(c_ready), .o_busy(c_busy),
        .o_overflow(c_ovf), .o_drop_cnt(c_cnt), .i_clr_overflow(c_clr)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Expected beats: {last, data}
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [8:0]  qc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_a(input logic [63:0] v);
        for (int c = 0; c < 4; c++) qa.push_back({c == 3, v[c*16 +: 16]});
    endtask

    task automatic push_b(input logic [63:0] v);
        for (int k = 0; k < 4; k++) qb.push_back({k == 3, v[(3-k)*16 +: 16]});
    endtask

    task automatic push_c(input logic [239:0] v);
        for (int k = 0; k < 30; k++) qc.push_back({k == 29, v[k*8 +: 8]});
    endtask

    // Returns one tick after the capture edge.
    task automatic pulse_a(input logic [63:0] v);
        @(posedge clk); #1 a_valid = 1'b1; a_data = v;
        @(posedge clk); #1 a_valid = 1'b0;
    endtask

    task automatic count_a(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (a_ovalid) n++;
        end
    endtask

    // Scoreboard monitor: pops on every transfer, checks stability across stalls.
    logic        a_stall = 1'b0;
    logic [15:0] a_hold_d = '0;
    logic        a_hold_l = 1'b0;

    initial begin
        logic [16:0] e16;
        logic [8:0]  e9;
        forever begin
            @(negedge clk);
            if (rst) begin
                a_stall = 1'b0;
            end else begin
                if (a_stall) begin
                    chk("a_stall_valid", 32'(a_ovalid), 32'd1);
                    chk("a_stall_data", 32'(a_odata), 32'(a_hold_d));
                    chk("a_stall_last", 32'(a_olast), 32'(a_hold_l));
                end
                a_stall  = a_ovalid && !a_ready;
                a_hold_d = a_odata;
                a_hold_l = a_olast;
                if (a_ovalid && a_ready) begin
                    if (qa.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL a_unexpected_beat: got %0h expected none", a_odata);
                    end else begin
                        e16 = qa.pop_front();
                        chk("a_beat", 32'({a_olast, a_odata}), 32'(e16));
                    end
                end
                if (b_ovalid && b_ready) begin
                    if (qb.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL b_unexpected_beat: got %0h expected none", b_odata);
                    end else begin
                        e16 = qb.pop_front();
                        chk("b_beat", 32'({b_olast, b_odata}), 32'(e16));
                    end
                end
                if (c_ovalid && c_ready) begin
                    if (qc.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL c_unexpected_beat: got %0h expected none", c_odata);
                    end else begin
                        e9 = qc.pop_front();
                        chk("c_beat", 32'({c_olast, c_odata}), 32'(e9));
                    end
                end
            end
        end
    end

    initial begin
        int          n, m;
        logic [6:0]  pat;
        logic [239:0] vc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(a_ovalid), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_data", 32'(a_odata), 32'd0);
        chk("rst_last", 32'(a_olast), 32'd0);
        chk("rst_ovf", 32'(a_ovf), 32'd0);
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        @(posedge clk); #3 rst = 1'b0;

        // 1: single vector, always ready
        push_a(V1);
        pulse_a(V1);
        chk("t1_latency", 32'(a_ovalid), 32'd1);
        count_a(8, n);
        chk("t1_valid_cycles", 32'(n), 32'd4);

        // 2: backpressure pattern 1,0,0,1,1,0,1
        pat = 7'b1011001;
        push_a(V1);
        @(posedge clk); #1 a_valid = 1'b1; a_data = V1;
        @(posedge clk); #1 a_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            a_ready = pat[i];
            @(posedge clk); #1;
        end
        a_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("t2_drained", 32'(a_busy), 32'd0);

        // 3: back-to-back vectors, no bubble
        push_a(V1);
        push_a(V2);
        @(posedge clk); #1 a_valid = 1'b1; a_data = V1;
        @(posedge clk); #1 a_data = V2;
        n = 0;
        @(negedge clk);
        if (a_ovalid) n++;
        @(posedge clk); #1 a_valid = 1'b0;
        count_a(7, m);
        chk("t3_contiguous", 32'(n + m), 32'd8);
        @(negedge clk);
        chk("t3_idle_after", 32'(a_ovalid), 32'd0);
        chk("t3_no_ovf", 32'(a_ovf), 32'd0);

        // 4: third vector dropped, fourth accepted on the final-beat cycle
        a_ready = 1'b0;
        push_a(V1);
        push_a(V2);
        @(posedge clk); #1 a_valid = 1'b1; a_data = V1;
        @(posedge clk); #1 a_data = V2;
        @(posedge clk); #1 a_data = V3;
        @(posedge clk); #1 a_valid = 1'b0;
        chk("t4_ovf", 32'(a_ovf), 32'd1);
        chk("t4_cnt", 32'(a_cnt), 32'd1);
        chk("t4_busy", 32'(a_busy), 32'd1);
        a_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 a_valid = 1'b1; a_data = V4;
        push_a(V4);
        @(posedge clk); #1 a_valid = 1'b0;
        chk("t4_v4_accepted", 32'(a_cnt), 32'd1);
        repeat (12) @(negedge clk);
        chk("t4_drained", 32'(a_busy), 32'd0);
        @(posedge clk); #1 a_clr = 1'b1;
        @(posedge clk); #1 a_clr = 1'b0;
        chk("t4_clr_ovf", 32'(a_ovf), 32'd0);
        chk("t4_clr_cnt", 32'(a_cnt), 32'd0);

        // Saturation, then drop beats clear in the same cycle
        a_ready = 1'b0;
        push_a(V1);
        push_a(V2);
        @(posedge clk); #1 a_valid = 1'b1; a_data = V1;
        @(posedge clk); #1 a_data = V2;
        @(posedge clk); #1 a_data = V3;
        repeat (259) @(posedge clk);
        #1 a_valid = 1'b0;
        chk("sat_cnt", 32'(a_cnt), 32'd255);
        @(posedge clk); #1 a_valid = 1'b1; a_clr = 1'b1;
        @(posedge clk); #1 a_valid = 1'b0; a_clr = 1'b0;
        chk("drop_wins_ovf", 32'(a_ovf), 32'd1);
        chk("drop_wins_cnt", 32'(a_cnt), 32'd1);
        @(posedge clk); #1 a_clr = 1'b1;
        @(posedge clk); #1 a_clr = 1'b0;
        chk("clr_cnt", 32'(a_cnt), 32'd0);
        a_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("sat_drained", 32'(a_busy), 32'd0);

        // 5: MSB-first order, and a 30-channel 8-bit stream
        push_b(V1);
        @(posedge clk); #1 b_valid = 1'b1; b_data = V1;
        @(posedge clk); #1 b_valid = 1'b0;
        chk("t5_b_latency", 32'(b_ovalid), 32'd1);
        repeat (6) @(negedge clk);
        chk("t5_b_drained", 32'(b_busy), 32'd0);
        for (int c = 0; c < 30; c++) vc[c*8 +: 8] = 8'(c + 1);
        push_c(vc);
        @(posedge clk); #1 c_valid = 1'b1; c_data = vc;
        @(posedge clk); #1 c_valid = 1'b0;
        n = 0;
        repeat (34) begin
            @(negedge clk);
            if (c_ovalid) n++;
        end
        chk("t5_c_valid_cycles", 32'(n), 32'd30);

        // 6: asynchronous reset mid-vector, then a fresh vector
        push_a(V1);
        pulse_a(V1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        qa.delete();
        #1;
        chk("t6_valid", 32'(a_ovalid), 32'd0);
        chk("t6_busy", 32'(a_busy), 32'd0);
        chk("t6_data", 32'(a_odata), 32'd0);
        chk("t6_last", 32'(a_olast), 32'd0);
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk);
        chk("t6_idle_after", 32'(a_ovalid), 32'd0);
        push_a(V2);
        pulse_a(V2);
        chk("t6_latency", 32'(a_ovalid), 32'd1);
        count_a(8, n);
        chk("t6_valid_cycles", 32'(n), 32'd4);

        chk("end_qa_empty", 32'(qa.size()), 32'd0);
        chk("end_qb_empty", 32'(qb.size()), 32'd0);
        chk("end_qc_empty", 32'(qc.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
